// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and 7-segment patterns shared with the keypad scanner
package keypad_pkg;
    localparam logic [3:0] KEY_BKSP = 4'd14;
    localparam logic [3:0] KEY_CLR  = 4'd15;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to {a..g} active-high segments, with forced blank
module seg7_decode
    import keypad_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/keypad_entry_display.sv
// keypad_entry_display: 4-digit key entry buffer driving a multiplexed 7-segment display
module keypad_entry_display
    import keypad_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DIGITS      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en,
    output logic [15:0]       value_bcd,
    output logic [2:0]        count,
    output logic              overflow
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] div_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    nxt_idx;
    logic [3:0]    nxt_nib;
    logic [6:0]    nxt_seg;
    logic          nxt_blank;
    logic          wrap;
    logic          is_digit;

    assign wrap      = div_cnt == CW'(REFRESH_DIV - 1);
    assign nxt_idx   = scan_idx + 2'd1;
    assign nxt_nib   = value_bcd[{nxt_idx, 2'b00} +: 4];
    assign nxt_blank = {1'b0, nxt_idx} >= count;
    assign is_digit  = key_code <= 4'd9;

    // Segments for the upcoming slot are sampled from the pre-event buffer
    seg7_decode u_dec (
        .bcd   (nxt_nib),
        .blank (nxt_blank),
        .seg   (nxt_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            dig_en   <= DIGITS'(1);
            seg      <= SEG_BLANK;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + CW'(1);
            if (wrap) begin
                scan_idx <= nxt_idx;
                dig_en   <= DIGITS'(1) << nxt_idx;
                seg      <= nxt_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_bcd <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= key_valid && is_digit && count == 3'd4;
            if (key_valid) begin
                if (is_digit) begin
                    value_bcd <= {value_bcd[11:0], key_code};
                    count     <= count == 3'd4 ? 3'd4 : count + 3'd1;
                end else if (key_code == KEY_BKSP && count != 3'd0) begin
                    value_bcd <= {4'h0, value_bcd[15:4]};
                    count     <= count - 3'd1;
                end else if (key_code == KEY_CLR) begin
                    value_bcd <= '0;
                    count     <= '0;
                end
            end
        end
    end
endmodule

// File: doc/keypad_entry_display.md
Name: keypad_entry_display

Overview:
- Downstream consumer of the keypad scanner. Takes decoded key events (code plus one-cycle valid) and builds a 4-digit decimal entry buffer.
- Supports digit shift-in, backspace (E) and clear (F).
- Drives a time-multiplexed 4-digit common-cathode 7-segment display with leading-zero blanking.
- Sits between the keypad scanner and the board display pins, replacing the single-digit direct drive.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2. At 50 MHz this gives 1 kHz per digit.
- DIGITS, 4: number of display digits. Fixed at 4; the parameter exists for documentation and must not be changed.

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid while high.
- key_code  in  4  0-9 digit, 14 (E) backspace, 15 (F) clear, 10-13 ignored.
- seg  out  7  segments {a,b,c,d,e,f,g}, bit6=a, active-high.
- dig_en  out  4  one-hot digit enable, active-high; bit0 = rightmost digit.
- value_bcd  out  16  buffer contents, 4 BCD nibbles; [3:0] = rightmost.
- count  out  3  number of entered digits, 0..4.
- overflow  out  1  one-cycle pulse when a digit entry discards the leftmost digit.

Behaviour:
- Reset (async assert, sync release): value_bcd=0, count=0, overflow=0, refresh counter=0, scan index=0, dig_en=4'b0001, seg=7'b0000000.
- Every cycle with key_valid=1 is one event. All events are processed in the same cycle, so results are visible the next cycle (latency 1).
- Digit d (0-9):
  - value_bcd <= {value_bcd[11:0], d}.
  - count <= min(count+1, 4).
  - If count was 4: the old [15:12] is lost and overflow pulses high for exactly 1 cycle.
- E (backspace):
  - value_bcd <= {4'h0, value_bcd[15:4]}.
  - count <= count-1, saturating at 0.
  - If count=0: no change.
- F (clear): value_bcd <= 0, count <= 0.
- Codes 10-13: no state change, no overflow.
- key_valid=0: key_code is ignored.
- Refresh counter: counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, scan index advances 0->1->2->3->0.
  - dig_en = one-hot(scan index), registered. It changes in the cycle after the wrap.
- seg is registered, updated in the same cycle as dig_en.
  - Source: the nibble at the scan index, decoded.
  - If scan index >= count, the digit is blank and seg=0. With count=0 all digits are blank.
- Decode table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other nibble -> 0000000.
- Display is not refreshed immediately on a key event. The new value appears when its slot is next scanned; worst case is 4*REFRESH_DIV+1 cycles.
- A key event in the same cycle as a refresh wrap: both take effect independently. seg for the new slot uses the pre-event buffer; the next slot visit shows the new value.
- Reset mid-operation clears the buffer and the scan position immediately.
- No handshake back-pressure: every event is consumed.

Decomposition:
- Shared package (keypad_pkg) holds:
  - key code constants KEY_BKSP=4'd14 and KEY_CLR=4'd15.
  - the 7-bit segment encoding constants SEG_0..SEG_9 and SEG_BLANK.
  - These are reused by the keypad scanner.
- One natural sub-module: seg7_decode, a combinational BCD-to-segment decoder with a blank input.
- Entry buffer and scan logic stay in the top module.

Test Plan (REFRESH_DIV=4):
- Reset, then observe 20 cycles -> seg=0 on all slots; dig_en cycles 0001,0010,0100,1000 with each value held 4 cycles.
- Keys 1,2,3 -> value_bcd=16'h0123, count=3; slot0 seg=1111001, slot1 seg=1101101, slot2 seg=0110000, slot3 seg=0000000.
- Keys 1,2,3,4,5 -> value_bcd=16'h2345, count=4; overflow high for exactly 1 cycle, on the cycle after the 5 is accepted; no overflow on keys 1-4.
- From 16'h2345, key E -> value_bcd=16'h0234, count=3; key E three more times -> 0, count=0; a fifth E -> no change.
- Key F with count=4 -> value=0, count=0, all slots blank. Key 11 -> no change.
- Assert rst_n low mid-scan with dig_en=0100 and value 16'h0789 -> all outputs take reset values asynchronously. After release, a key 7 event -> value_bcd=16'h0007.
